// File: rtl/adder_error_monitor_pkg.sv
// Shared types and arithmetic helpers for the approximate-adder error monitor.
package adder_error_monitor_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDone
    } state_e;

    localparam int unsigned MaxW = 64;

    // Operands arrive zero-extended above 'width'; sign extension is applied here when requested.
    function automatic logic [MaxW:0] abs_diff(input logic [MaxW-1:0] a,
                                               input logic [MaxW-1:0] b,
                                               input int unsigned     width,
                                               input logic            is_signed);
        logic [MaxW:0] hi;
        logic [MaxW:0] ax;
        logic [MaxW:0] bx;
        logic [MaxW:0] d;
        hi = {(MaxW + 1){1'b1}} << width;
        ax = {1'b0, a};
        bx = {1'b0, b};
        if (is_signed && (((a >> (width - 1)) & 64'd1) != '0)) begin
            ax = ax | hi;
        end
        if (is_signed && (((b >> (width - 1)) & 64'd1) != '0)) begin
            bx = bx | hi;
        end
        d = ax - bx;
        if (d[MaxW]) begin
            d = -d;
        end
        return d;
    endfunction

    function automatic logic [MaxW-1:0] sat_add(input logic [MaxW-1:0] acc,
                                                input logic [MaxW-1:0] inc,
                                                input int unsigned     width);
        logic [MaxW:0] s;
        logic [MaxW:0] lim;
        s   = {1'b0, acc} + {1'b0, inc};
        lim = ({{MaxW{1'b0}}, 1'b1} << width) - 1'b1;
        return (s > lim) ? lim[MaxW-1:0] : s[MaxW-1:0];
    endfunction

endpackage

// File: rtl/adder_error_monitor_adder_generic.sv
// Generic adder of the approximate-adder family; ADD_TYPE 0 is the exact reference.
module Adder_generic #(
    parameter int unsigned ADD_TYPE  = 0,
    parameter int unsigned WIDTH_A   = 16,
    parameter int unsigned WIDTH_B   = 16,
    parameter int unsigned WIDTH_OUT = 17,
    parameter int unsigned SIGNED    = 0
) (
    input  logic [WIDTH_A-1:0]   i_a,
    input  logic [WIDTH_B-1:0]   i_b,
    input  logic                 i_carry,
    output logic [WIDTH_OUT-1:0] o_sum
);

    logic [WIDTH_OUT-1:0] w_a;
    logic [WIDTH_OUT-1:0] w_b;
    logic [WIDTH_OUT-1:0] w_exact;

    if (SIGNED != 0) begin : g_sext
        assign w_a = WIDTH_OUT'($signed(i_a));
        assign w_b = WIDTH_OUT'($signed(i_b));
    end else begin : g_zext
        assign w_a = WIDTH_OUT'(i_a);
        assign w_b = WIDTH_OUT'(i_b);
    end

    assign w_exact = w_a + w_b + WIDTH_OUT'(i_carry);

    if (ADD_TYPE == 0) begin : g_exact
        assign o_sum = w_exact;
    end else begin : g_lsb_or
        // Cheapest family member: the LSB is an OR instead of a full-adder bit.
        assign o_sum = {w_exact[WIDTH_OUT-1:1], w_a[0] | w_b[0] | i_carry};
    end

endmodule

// File: rtl/adder_error_monitor.sv
// Compares an approximate adder's output against the exact sum and accumulates
// error statistics over a programmed window of samples.
module adder_error_monitor
    import adder_error_monitor_pkg::*;
#(
    parameter int unsigned WIDTH_A   = 16,
    parameter int unsigned WIDTH_B   = 16,
    parameter int unsigned WIDTH_OUT = 16,
    parameter int unsigned SIGNED    = 0,
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned ACC_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     window_len,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_A-1:0]   A,
    input  logic [WIDTH_B-1:0]   B,
    input  logic                 Carry,
    input  logic [WIDTH_OUT-1:0] APPROX_OUT,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [CNT_W-1:0]     err_count,
    output logic [WIDTH_OUT:0]   max_err,
    output logic [ACC_W-1:0]     sum_err,
    output logic                 busy
);

    localparam int unsigned SUM_W = ((WIDTH_A > WIDTH_B) ? WIDTH_A : WIDTH_B) + 1;
    localparam int unsigned ERR_W = WIDTH_OUT + 1;

    state_e               r_state;
    state_e               w_state_next;
    logic [CNT_W-1:0]     r_window;
    logic [CNT_W-1:0]     r_count;
    logic                 r_s0_valid;
    logic [WIDTH_OUT-1:0] r_s0_exact;
    logic [WIDTH_OUT-1:0] r_s0_approx;
    logic [CNT_W-1:0]     r_err_count;
    logic [ERR_W-1:0]     r_max_err;
    logic [ACC_W-1:0]     r_sum_err;

    logic [SUM_W-1:0]     w_sum;
    logic [WIDTH_OUT-1:0] w_exact;
    logic [ERR_W-1:0]     w_err;
    logic                 w_start;
    logic                 w_accept;

    Adder_generic #(
        .ADD_TYPE  (0),
        .WIDTH_A   (WIDTH_A),
        .WIDTH_B   (WIDTH_B),
        .WIDTH_OUT (SUM_W),
        .SIGNED    (SIGNED)
    ) u_golden (
        .i_a     (A),
        .i_b     (B),
        .i_carry (Carry),
        .o_sum   (w_sum)
    );

    if (SIGNED != 0) begin : g_trunc_s
        assign w_exact = WIDTH_OUT'($signed(w_sum));
    end else begin : g_trunc_u
        assign w_exact = WIDTH_OUT'(w_sum);
    end

    assign w_err = ERR_W'(abs_diff(MaxW'(r_s0_exact), MaxW'(r_s0_approx), WIDTH_OUT,
                                   SIGNED != 0));

    assign w_start   = (r_state == StIdle) && start;
    assign in_ready  = (r_state == StCollect) && (r_count != r_window);
    assign w_accept  = in_valid && in_ready;
    assign res_valid = (r_state == StDone);
    assign busy      = (r_state != StIdle);
    assign err_count = r_err_count;
    assign max_err   = r_max_err;
    assign sum_err   = r_sum_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Once the count reaches the window, stage 0 holds the last sample, so the
    // DONE transition coincides with its statistics update.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_state_next = (window_len == '0) ? StDone : StCollect;
                end
            end
            StCollect: begin
                if (r_count == r_window) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                if (res_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_window    <= '0;
            r_count     <= '0;
            r_s0_valid  <= 1'b0;
            r_s0_exact  <= '0;
            r_s0_approx <= '0;
            r_err_count <= '0;
            r_max_err   <= '0;
            r_sum_err   <= '0;
        end else begin
            r_s0_valid <= w_accept;
            if (w_accept) begin
                r_s0_exact  <= w_exact;
                r_s0_approx <= APPROX_OUT;
                r_count     <= r_count + 1'b1;
            end
            if (w_start) begin
                r_window    <= window_len;
                r_count     <= '0;
                r_err_count <= '0;
                r_max_err   <= '0;
                r_sum_err   <= '0;
            end else if (r_s0_valid) begin
                r_err_count <= r_err_count + CNT_W'(w_err != '0);
                if (w_err > r_max_err) begin
                    r_max_err <= w_err;
                end
                r_sum_err <= ACC_W'(sat_add(MaxW'(r_sum_err), MaxW'(w_err), ACC_W));
            end
        end
    end

endmodule

// File: tb/tb_adder_error_monitor.sv
// Scoreboard bench: an unsigned 8-bit monitor and a signed 8-bit monitor with a
// 4-bit accumulator so saturation is reachable.
module tb_adder_error_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_u;
    logic        start_s;
    logic [15:0] window_len_u;
    logic [3:0]  window_len_s;
    logic        in_valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic        Carry;
    logic [7:0]  APPROX_OUT;
    logic        res_ready;

    logic        in_ready_u;
    logic        res_valid_u;
    logic [15:0] err_count_u;
    logic [8:0]  max_err_u;
    logic [31:0] sum_err_u;
    logic        busy_u;

    logic        in_ready_s;
    logic        res_valid_s;
    logic [3:0]  err_count_s;
    logic [8:0]  max_err_s;
    logic [3:0]  sum_err_s;
    logic        busy_s;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    adder_error_monitor #(
        .WIDTH_A (8), .WIDTH_B (8), .WIDTH_OUT (8), .SIGNED (0), .CNT_W (16), .ACC_W (32)
    ) u_dut_u (
        .clk (clk), .rst (rst), .start (start_u), .window_len (window_len_u),
        .in_valid (in_valid), .in_ready (in_ready_u), .A (A), .B (B), .Carry (Carry),
        .APPROX_OUT (APPROX_OUT), .res_valid (res_valid_u), .res_ready (res_ready),
        .err_count (err_count_u), .max_err (max_err_u), .sum_err (sum_err_u), .busy (busy_u)
    );

    adder_error_monitor #(
        .WIDTH_A (8), .WIDTH_B (8), .WIDTH_OUT (8), .SIGNED (1), .CNT_W (4), .ACC_W (4)
    ) u_dut_s (
        .clk (clk), .rst (rst), .start (start_s), .window_len (window_len_s),
        .in_valid (in_valid), .in_ready (in_ready_s), .A (A), .B (B), .Carry (Carry),
        .APPROX_OUT (APPROX_OUT), .res_valid (res_valid_s), .res_ready (res_ready),
        .err_count (err_count_s), .max_err (max_err_s), .sum_err (sum_err_s), .busy (busy_s)
    );

    typedef struct {
        longint unsigned cnt;
        longint unsigned mx;
        longint unsigned sum;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned sa[16];
    int unsigned sb[16];
    int unsigned sc[16];
    int unsigned sp[16];

    task automatic check_eq(input string tag, input longint unsigned got,
                            input longint unsigned want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int err_model(input int unsigned a, input int unsigned b,
                                     input int unsigned c, input int unsigned p,
                                     input bit sgn);
        int ex;
        int ap;
        int d;
        ex = int'((a + b + c) % 256);
        ap = int'(p);
        if (sgn) begin
            if (ex >= 128) ex = ex - 256;
            if (ap >= 128) ap = ap - 256;
        end
        d = ex - ap;
        return (d < 0) ? -d : d;
    endfunction

    function automatic longint unsigned get_cnt(input bit sgn);
        return sgn ? longint'(err_count_s) : longint'(err_count_u);
    endfunction
    function automatic longint unsigned get_max(input bit sgn);
        return sgn ? longint'(max_err_s) : longint'(max_err_u);
    endfunction
    function automatic longint unsigned get_sum(input bit sgn);
        return sgn ? longint'(sum_err_s) : longint'(sum_err_u);
    endfunction
    function automatic logic get_ir(input bit sgn);
        return sgn ? in_ready_s : in_ready_u;
    endfunction
    function automatic logic get_rv(input bit sgn);
        return sgn ? res_valid_s : res_valid_u;
    endfunction
    function automatic logic get_busy(input bit sgn);
        return sgn ? busy_s : busy_u;
    endfunction

    task automatic check_stats(input string tag, input bit sgn, input exp_t e);
        check_eq({tag, "_err_count"}, get_cnt(sgn), e.cnt);
        check_eq({tag, "_max_err"}, get_max(sgn), e.mx);
        check_eq({tag, "_sum_err"}, get_sum(sgn), e.sum);
    endtask

    task automatic run_window(input string tag, input int n, input bit sgn, input bit gaps,
                              input int hold, input bit poke_start);
        exp_t e;
        int   err;
        int   acc;
        int   last_acc;
        int   guard;
        bit   took;
        e = '{cnt: 0, mx: 0, sum: 0};
        for (int i = 0; i < n; i++) begin
            err = err_model(sa[i], sb[i], sc[i], sp[i], sgn);
            if (err != 0) e.cnt++;
            if (longint'(err) > e.mx) e.mx = longint'(err);
            e.sum += longint'(err);
            if (sgn && e.sum > 15) e.sum = 15;
        end
        exp_q.push_back(e);

        window_len_u = 16'(n);
        window_len_s = 4'(n);
        if (sgn) start_s = 1'b1;
        else start_u = 1'b1;
        tick();
        start_u  = 1'b0;
        start_s  = 1'b0;
        last_acc = cyc - 1;
        acc      = 0;
        guard    = 0;
        while (acc < n && guard < 200) begin
            in_valid   = gaps ? (guard % 3 != 1) : 1'b1;
            A          = 8'(sa[acc]);
            B          = 8'(sb[acc]);
            Carry      = sc[acc][0];
            APPROX_OUT = 8'(sp[acc]);
            took       = in_valid && get_ir(sgn);
            tick();
            guard++;
            if (took) begin
                acc++;
                last_acc = cyc;
            end
        end
        in_valid = 1'b0;
        if (acc < n) check_eq({tag, "_accept_timeout"}, longint'(acc), longint'(n));
        if (n > 0) check_eq({tag, "_in_ready_drop"}, longint'(get_ir(sgn)), 0);

        guard = 0;
        while (!get_rv(sgn) && guard < 20) begin
            tick();
            guard++;
        end
        check_eq({tag, "_res_valid"}, longint'(get_rv(sgn)), 1);
        check_eq({tag, "_latency"}, longint'(cyc), longint'(last_acc + 1));
        check_eq({tag, "_in_ready_done"}, longint'(get_ir(sgn)), 0);
        e = exp_q.pop_front();
        check_stats(tag, sgn, e);

        for (int h = 0; h < hold; h++) begin
            if (poke_start && h == 1) begin
                if (sgn) start_s = 1'b1;
                else start_u = 1'b1;
            end
            tick();
            start_u = 1'b0;
            start_s = 1'b0;
            check_eq({tag, "_hold_res_valid"}, longint'(get_rv(sgn)), 1);
            check_eq({tag, "_hold_in_ready"}, longint'(get_ir(sgn)), 0);
            check_stats({tag, "_hold"}, sgn, e);
        end

        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check_eq({tag, "_idle_busy"}, longint'(get_busy(sgn)), 0);
        check_eq({tag, "_idle_res_valid"}, longint'(get_rv(sgn)), 0);
        check_stats({tag, "_after"}, sgn, e);
    endtask

    initial begin
        rst          = 1'b1;
        start_u      = 1'b0;
        start_s      = 1'b0;
        window_len_u = '0;
        window_len_s = '0;
        in_valid     = 1'b0;
        A            = '0;
        B            = '0;
        Carry        = 1'b0;
        APPROX_OUT   = '0;
        res_ready    = 1'b0;
        tick();
        tick();
        check_eq("reset_busy", longint'(busy_u), 0);
        check_eq("reset_res_valid", longint'(res_valid_u), 0);
        check_eq("reset_in_ready", longint'(in_ready_u), 0);
        check_stats("reset", 1'b0, '{cnt: 0, mx: 0, sum: 0});
        check_eq("reset_busy_s", longint'(busy_s), 0);
        rst = 1'b0;
        tick();

        // Exact match
        for (int i = 0; i < 4; i++) begin
            sa[i] = (i * 37 + 11) % 256;
            sb[i] = (i * 91 + 200) % 256;
            sc[i] = i % 2;
            sp[i] = (sa[i] + sb[i] + sc[i]) % 256;
        end
        run_window("exact", 4, 1'b0, 1'b0, 0, 1'b0);

        // Error accumulation
        for (int i = 0; i < 2; i++) begin
            sa[i] = 200;
            sb[i] = 100;
            sc[i] = 0;
        end
        sp[0] = 40;
        sp[1] = 50;
        run_window("accum", 2, 1'b0, 1'b0, 0, 1'b0);

        run_window("empty", 0, 1'b0, 1'b0, 0, 1'b0);

        // Backpressure and ignored start
        for (int i = 0; i < 3; i++) begin
            sa[i] = $urandom_range(0, 255);
            sb[i] = $urandom_range(0, 255);
            sc[i] = $urandom_range(0, 1);
            sp[i] = $urandom_range(0, 255);
        end
        run_window("backpressure", 3, 1'b0, 1'b1, 5, 1'b1);

        // Signed
        sa[0] = 8'hFD;
        sb[0] = 8'h01;
        sc[0] = 0;
        sp[0] = 8'h02;
        run_window("signed", 1, 1'b1, 1'b0, 0, 1'b0);

        // Random windows; the signed one saturates its 4-bit accumulator
        for (int i = 0; i < 8; i++) begin
            sa[i] = $urandom_range(0, 255);
            sb[i] = $urandom_range(0, 255);
            sc[i] = $urandom_range(0, 1);
            sp[i] = (sa[i] + sb[i] + sc[i] + ((i % 3 == 0) ? 0 : $urandom_range(0, 9))) % 256;
        end
        run_window("rand_u", 6, 1'b0, 1'b1, 0, 1'b0);
        for (int i = 0; i < 8; i++) sp[i] = $urandom_range(0, 255);
        run_window("rand_s", 8, 1'b1, 1'b0, 0, 1'b0);

        // Reset mid-window
        window_len_u = 16'd5;
        start_u      = 1'b1;
        tick();
        start_u    = 1'b0;
        in_valid   = 1'b1;
        A          = 8'd10;
        B          = 8'd20;
        Carry      = 1'b0;
        APPROX_OUT = 8'd0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_eq("midrst_busy", longint'(busy_u), 0);
        check_eq("midrst_in_ready", longint'(in_ready_u), 0);
        check_eq("midrst_res_valid", longint'(res_valid_u), 0);
        check_stats("midrst", 1'b0, '{cnt: 0, mx: 0, sum: 0});
        in_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        sa[0] = 33;
        sb[0] = 44;
        sc[0] = 1;
        sp[0] = 78;
        run_window("post_reset", 1, 1'b0, 1'b0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
